// File: rtl/gcdq_pkg.sv
// Shared constants for the GCD job queue: register offsets, STATUS bit
// positions and the dispatcher state encoding.
package gcdq_pkg;

    localparam logic [15:0] OFF_OP_A   = 16'h0000;
    localparam logic [15:0] OFF_OP_B   = 16'h0004;
    localparam logic [15:0] OFF_RESULT = 16'h0008;
    localparam logic [15:0] OFF_STATUS = 16'h000C;
    localparam logic [15:0] OFF_COUNT  = 16'h0010;

    localparam int ST_JOB_EMPTY = 0;
    localparam int ST_JOB_FULL  = 1;
    localparam int ST_RES_EMPTY = 2;
    localparam int ST_RES_FULL  = 3;
    localparam int ST_BUSY      = 4;
    localparam int ST_OVF       = 5;
    localparam int ST_UNF       = 6;
    localparam int ST_LEVEL_LSB = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;

endpackage

// File: rtl/gcdq_fifo.sv
// Synchronous fall-through FIFO; pushes when full and pops when empty are
// silently ignored so the caller only has to flag them.
module gcdq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/gcd_job_queue.sv
// Bus front end for the GCD engine: CPU queues operand pairs, a dispatcher
// runs them through the engine one at a time and queues results for readback.
module gcd_job_queue
    import gcdq_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter int          DW    = 32,
    parameter logic [15:0] BASE  = 16'h0108
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic [15:0]   saddress,
    input  logic          srd,
    input  logic          swr,
    input  logic [DW-1:0] sdata_in,
    output logic [DW-1:0] sdata_out,
    output logic [DW-1:0] eng_a,
    output logic [DW-1:0] eng_b,
    output logic          eng_start,
    input  logic          eng_done,
    input  logic [DW-1:0] eng_result,
    output logic [31:0]   gpio_out
);
    localparam int LW = $clog2(DEPTH) + 1;

    state_t          state;
    logic            srd_q, swr_q, rd_fire, wr_fire;
    logic            hit_a, hit_b, hit_res, hit_stat, hit_cnt;
    logic [DW-1:0]   a_hold, res_q;
    logic            ovf, unf;
    logic [2*DW-1:0] job_head;
    logic [DW-1:0]   res_head;
    logic            job_full, job_empty, res_full, res_empty;
    logic [LW-1:0]   job_level, res_level;
    logic [31:0]     status;

    assign rd_fire  = srd && !srd_q;
    assign wr_fire  = swr && !swr_q;
    assign hit_a    = (saddress == BASE + OFF_OP_A);
    assign hit_b    = (saddress == BASE + OFF_OP_B);
    assign hit_res  = (saddress == BASE + OFF_RESULT);
    assign hit_stat = (saddress == BASE + OFF_STATUS);
    assign hit_cnt  = (saddress == BASE + OFF_COUNT);

    gcdq_fifo #(.DEPTH(DEPTH), .W(2*DW)) u_job_fifo (
        .clk(clk), .n_reset(n_reset),
        .push(wr_fire && hit_b), .pop(state == ISSUE),
        .din({a_hold, sdata_in}), .dout(job_head),
        .full(job_full), .empty(job_empty), .level(job_level)
    );

    gcdq_fifo #(.DEPTH(DEPTH), .W(DW)) u_res_fifo (
        .clk(clk), .n_reset(n_reset),
        .push(state == STORE), .pop(rd_fire && hit_res),
        .din(res_q), .dout(res_head),
        .full(res_full), .empty(res_empty), .level(res_level)
    );

    always_comb begin
        status                       = '0;
        status[ST_JOB_EMPTY]         = job_empty;
        status[ST_JOB_FULL]          = job_full;
        status[ST_RES_EMPTY]         = res_empty;
        status[ST_RES_FULL]          = res_full;
        status[ST_BUSY]              = (state != IDLE);
        status[ST_OVF]               = ovf;
        status[ST_UNF]               = unf;
        status[ST_LEVEL_LSB +: 8]    = 8'(job_level);
    end

    // Bus side. Flag sets are written after W1C clears so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            srd_q     <= 1'b0;
            swr_q     <= 1'b0;
            a_hold    <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            sdata_out <= '0;
        end else begin
            srd_q <= srd;
            swr_q <= swr;
            if (wr_fire) begin
                if (hit_a) a_hold <= sdata_in;
                if (hit_stat && sdata_in[ST_OVF]) ovf <= 1'b0;
                if (hit_stat && sdata_in[ST_UNF]) unf <= 1'b0;
                if (hit_b && job_full) ovf <= 1'b1;
            end
            if (rd_fire) begin
                if (hit_a)    sdata_out <= a_hold;
                if (hit_stat) sdata_out <= DW'(status);
                if (hit_cnt)  sdata_out <= DW'(gpio_out);
                if (hit_res) begin
                    sdata_out <= res_empty ? '0 : res_head;
                    if (res_empty) unf <= 1'b1;
                end
            end
        end
    end

    // Operands load on the IDLE->ISSUE edge so eng_start is high exactly in ISSUE.
    // Only one job is ever in flight, so a free result slot seen in IDLE stays free.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= IDLE;
            eng_a     <= '0;
            eng_b     <= '0;
            eng_start <= 1'b0;
            res_q     <= '0;
            gpio_out  <= '0;
        end else begin
            case (state)
                IDLE: if (!job_empty && !res_full) begin
                    eng_a     <= job_head[2*DW-1:DW];
                    eng_b     <= job_head[DW-1:0];
                    eng_start <= (job_head[2*DW-1:DW] != '0) && (job_head[DW-1:0] != '0);
                    state     <= ISSUE;
                end
                ISSUE: begin
                    eng_start <= 1'b0;
                    if (eng_a == '0 || eng_b == '0) begin
                        res_q <= eng_a | eng_b;
                        state <= STORE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (eng_done) begin
                    res_q <= eng_result;
                    state <= STORE;
                end
                STORE: begin
                    gpio_out <= gpio_out + 32'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
